dta_snd_protocol_checker: RTL and testbench

DTA_SND_PROTOCOL_CHECKER -- requirements
Module: dta_snd_protocol_checker

---
 rtl/dta_snd_protocol_pkg.sv | 39 +++
 rtl/dta_snd_protocol_fifo.sv | 50 +++++
 rtl/dta_snd_protocol_checker.sv | 137 +++++++++++++
 tb/tb_dta_snd_protocol_checker.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dta_snd_protocol_pkg.sv
// rtl/dta_snd_protocol_pkg.sv - descriptor field positions, error bit indices and shared types
package dta_snd_protocol_pkg;

  localparam int CH_LSB  = 0;
  localparam int CH_W    = 16;
  localparam int SOF_BIT = 16;
  localparam int EOF_BIT = 17;
  localparam int LEN_LSB = 48;
  localparam int LEN_W   = 16;

  localparam int ERR_CH          = 0;
  localparam int ERR_LEN_GT      = 1;
  localparam int ERR_SOF         = 2;
  localparam int ERR_EOF         = 3;
  localparam int ERR_REQ_OVF     = 6;
  localparam int ERR_RESP_ORPHAN = 7;
  localparam int ERR_BURST_MAX   = 8;
  localparam int ERR_DATA_ORPHAN = 9;
  localparam int ERR_ZERO_LEN    = 12;
  localparam int ERR_STRICT_LEN  = 13;

  typedef logic [15:0] err_vec_t;

  // Bits that can ever be raised; the rest are tied low.
  localparam err_vec_t ERR_LIVE_MASK = 16'h33CF;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             eof;
    logic             sof;
    logic [CH_W-1:0]  channel;
  } desc_t;

  function automatic logic [16:0] burst_beats(input logic [15:0] len_bytes,
                                              input int unsigned bytes_log2);
    return (17'(len_bytes) + ((17'd1 << bytes_log2) - 17'd1)) >> bytes_log2;
  endfunction

endpackage

// File: rtl/dta_snd_protocol_fifo.sv
// rtl/dta_snd_protocol_fifo.sv - first-word-fall-through sync FIFO with occupancy count
module dta_snd_protocol_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push != do_pop) count_q <= do_push ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dta_snd_protocol_checker.sv
// rtl/dta_snd_protocol_checker.sv - passive req/resp/data stream protocol monitor
module dta_snd_protocol_checker
  import dta_snd_protocol_pkg::*;
#(
  parameter int          DATA_W          = 512,
  parameter int          MAX_OUTSTANDING = 16,
  parameter logic [15:0] MAX_BURST       = 16'd32768,
  parameter bit          STRICT_LEN      = 1'b0
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             req_tvalid,
  input  logic                             req_tready,
  input  logic [63:0]                      req_tdata,
  input  logic                             resp_tvalid,
  input  logic                             resp_tready,
  input  logic [63:0]                      resp_tdata,
  input  logic                             data_tvalid,
  input  logic                             data_tready,
  input  logic [DATA_W-1:0]                data_tdata,
  input  logic [15:0]                      err_mask,
  input  logic                             err_clear,
  output logic [15:0]                      protocol_error,
  output logic                             protocol_error_ap_vld,
  output logic [31:0]                      error_count,
  output logic [15:0]                      first_error,
  output logic [$clog2(MAX_OUTSTANDING):0] req_outstanding,
  output logic [$clog2(MAX_OUTSTANDING):0] resp_outstanding
);

  localparam int unsigned BEAT_LOG2 = $clog2(DATA_W/8);

  logic        req_acc, resp_acc, data_acc;
  desc_t       req_desc, resp_desc, head_req;
  logic        req_full, req_empty, req_pop;
  logic        resp_full, resp_empty, resp_push, resp_pop, data_hit;
  logic [16:0] resp_beats, head_beats, consumed_q;
  logic        quiet_q;
  err_vec_t    raw, evt, err_base, first_base, err_q, err_d, first_q, first_d;
  logic [31:0] cnt_base, cnt_q, cnt_d;
  logic        vld_q, vld_d;

  assign req_acc  = req_tvalid && req_tready;
  assign resp_acc = resp_tvalid && resp_tready;
  assign data_acc = data_tvalid && data_tready;

  assign req_desc  = '{len: req_tdata[LEN_LSB +: LEN_W], eof: req_tdata[EOF_BIT],
                       sof: req_tdata[SOF_BIT], channel: req_tdata[CH_LSB +: CH_W]};
  assign resp_desc = '{len: resp_tdata[LEN_LSB +: LEN_W], eof: resp_tdata[EOF_BIT],
                       sof: resp_tdata[SOF_BIT], channel: resp_tdata[CH_LSB +: CH_W]};

  assign req_pop    = resp_acc && !req_empty;
  assign resp_beats = burst_beats(resp_desc.len, BEAT_LOG2);
  assign resp_push  = resp_acc && (resp_desc.len != '0);
  assign data_hit   = data_acc && !resp_empty;
  assign resp_pop   = data_hit && (consumed_q + 17'd1 == head_beats);

  dta_snd_protocol_fifo #(.WIDTH($bits(desc_t)), .DEPTH(MAX_OUTSTANDING)) u_req_q (
    .clk_i(ap_clk), .rst_ni(ap_rst_n), .push_i(req_acc), .data_i(req_desc),
    .pop_i(req_pop), .data_o(head_req), .full_o(req_full), .empty_o(req_empty),
    .count_o(req_outstanding)
  );

  dta_snd_protocol_fifo #(.WIDTH(17), .DEPTH(MAX_OUTSTANDING)) u_resp_q (
    .clk_i(ap_clk), .rst_ni(ap_rst_n), .push_i(resp_push), .data_i(resp_beats),
    .pop_i(resp_pop), .data_o(head_beats), .full_o(resp_full), .empty_o(resp_empty),
    .count_o(resp_outstanding)
  );

  always_comb begin
    raw = '0;
    if (req_acc) begin
      raw[ERR_ZERO_LEN]  = (req_desc.len == '0);
      raw[ERR_BURST_MAX] = (req_desc.len > MAX_BURST);
      raw[ERR_REQ_OVF]   = req_full && !req_pop;
    end
    if (resp_acc) begin
      // Emptiness is judged before this cycle's push, so a same-cycle req does not match.
      if (req_empty) begin
        raw[ERR_RESP_ORPHAN] = 1'b1;
      end else begin
        raw[ERR_CH]         = (resp_desc.channel != head_req.channel);
        raw[ERR_LEN_GT]     = (resp_desc.len > head_req.len);
        raw[ERR_SOF]        = (resp_desc.sof != head_req.sof);
        raw[ERR_EOF]        = (resp_desc.eof != head_req.eof);
        raw[ERR_STRICT_LEN] = STRICT_LEN && (resp_desc.len != head_req.len);
      end
      if (resp_push && resp_full && !resp_pop) raw[ERR_RESP_ORPHAN] = 1'b1;
    end
    if (data_acc && resp_empty) raw[ERR_DATA_ORPHAN] = 1'b1;
  end

  assign evt = quiet_q ? '0 : (raw & ~err_mask & ERR_LIVE_MASK);

  // Clear applies first so an event in the same cycle lands on a clean slate.
  always_comb begin
    err_base   = err_clear ? '0 : err_q;
    first_base = err_clear ? '0 : first_q;
    cnt_base   = err_clear ? '0 : cnt_q;
    err_d      = err_base | evt;
    vld_d      = |(evt & ~err_base);
    first_d    = ((first_base == '0) && (evt != '0)) ? evt : first_base;
    cnt_d      = ((evt != '0) && (cnt_base != '1)) ? cnt_base + 32'd1 : cnt_base;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      quiet_q    <= 1'b1;
      consumed_q <= '0;
      err_q      <= '0;
      first_q    <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      quiet_q <= 1'b0;
      if (resp_pop)      consumed_q <= '0;
      else if (data_hit) consumed_q <= consumed_q + 17'd1;
      err_q   <= err_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  assign protocol_error        = err_q;
  assign protocol_error_ap_vld = vld_q;
  assign error_count           = cnt_q;
  assign first_error           = first_q;

  a_req_known: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    req_acc |-> !$isunknown(req_tdata));
  a_resp_known: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    resp_acc |-> !$isunknown(resp_tdata));
  a_data_known: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    data_acc |-> !$isunknown(data_tdata));

endmodule

// File: tb/tb_dta_snd_protocol_checker.sv
// tb/tb_dta_snd_protocol_checker.sv - directed vector bench for dta_snd_protocol_checker
module tb_dta_snd_protocol_checker;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         req_tvalid = 1'b0, req_tready = 1'b0;
  logic [63:0]  req_tdata = '0;
  logic         resp_tvalid = 1'b0, resp_tready = 1'b0;
  logic [63:0]  resp_tdata = '0;
  logic         data_tvalid = 1'b0, data_tready = 1'b0;
  logic [511:0] data_tdata = '0;
  logic [15:0]  err_mask = '0;
  logic         err_clear = 1'b0;
  logic [15:0]  protocol_error;
  logic         protocol_error_ap_vld;
  logic [31:0]  error_count;
  logic [15:0]  first_error;
  logic [4:0]   req_outstanding, resp_outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  dta_snd_protocol_checker #(.DATA_W(512), .MAX_OUTSTANDING(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .resp_tvalid(resp_tvalid), .resp_tready(resp_tready), .resp_tdata(resp_tdata),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
    .err_mask(err_mask), .err_clear(err_clear),
    .protocol_error(protocol_error), .protocol_error_ap_vld(protocol_error_ap_vld),
    .error_count(error_count), .first_error(first_error),
    .req_outstanding(req_outstanding), .resp_outstanding(resp_outstanding)
  );

  typedef struct {
    logic        req_v;
    logic [63:0] req_d;
    logic        resp_v;
    logic [63:0] resp_d;
    logic        data_v;
    logic        rdy;
    logic [15:0] mask;
    logic        clr;
    logic [15:0] e_prot;
    logic        e_vld;
    int          e_cnt;
    logic [15:0] e_first;
    int          e_reqo;
    int          e_respo;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [63:0] d(input logic [15:0] ch, input logic [15:0] len,
                                    input logic sof, input logic eof);
    return {len, 30'd0, eof, sof, ch};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] prot, input logic vld,
                           input int cnt, input logic [15:0] first, input int reqo, input int respo);
    check({tag, ".prot"},  32'(protocol_error), 32'(prot));
    check({tag, ".vld"},   32'(protocol_error_ap_vld), 32'(vld));
    check({tag, ".cnt"},   error_count, cnt);
    check({tag, ".first"}, 32'(first_error), 32'(first));
    check({tag, ".reqo"},  32'(req_outstanding), reqo);
    check({tag, ".respo"}, 32'(resp_outstanding), respo);
  endtask

  task automatic drive(input logic rv, input logic [63:0] rd, input logic pv, input logic [63:0] pd,
                       input logic dv, input logic rdy, input logic [15:0] mask, input logic clr);
    req_tvalid = rv;  req_tdata = rd;  req_tready = rdy;
    resp_tvalid = pv; resp_tdata = pd; resp_tready = rdy;
    data_tvalid = dv; data_tdata = {16{32'hA5A5_0000 | 32'(n_cmp)}}; data_tready = rdy;
    err_mask = mask;  err_clear = clr;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 16'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    //            req_v req_d               resp_v resp_d             dv rdy mask     clr prot     vld cnt first    reqo respo
    vecs[0]  = '{1'b1, d(3,128,1,1),     1'b0, 64'd0,             0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 0};
    vecs[1]  = '{1'b0, 64'd0,            1'b1, d(3,128,1,1),      0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 1};
    vecs[2]  = '{1'b0, 64'd0,            1'b0, 64'd0,             1, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 1};
    vecs[3]  = '{1'b0, 64'd0,            1'b0, 64'd0,             1, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0};
    vecs[4]  = '{1'b1, d(3,64,1,1),      1'b0, 64'd0,             0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 0};
    vecs[5]  = '{1'b0, 64'd0,            1'b1, d(5,64,1,1),       0, 1, 16'h0000, 0, 16'h0001, 1, 1, 16'h0001, 0, 1};
    vecs[6]  = '{1'b0, 64'd0,            1'b0, 64'd0,             0, 1, 16'h0000, 0, 16'h0001, 0, 1, 16'h0001, 0, 1};
    vecs[7]  = '{1'b0, 64'd0,            1'b0, 64'd0,             1, 1, 16'h0000, 0, 16'h0001, 0, 1, 16'h0001, 0, 0};
    vecs[8]  = '{1'b0, 64'd0,            1'b0, 64'd0,             1, 1, 16'h0200, 0, 16'h0001, 0, 1, 16'h0001, 0, 0};
    vecs[9]  = '{1'b0, 64'd0,            1'b0, 64'd0,             1, 1, 16'h0000, 0, 16'h0201, 1, 2, 16'h0001, 0, 0};
    vecs[10] = '{1'b1, d(1,0,0,0),       1'b0, 64'd0,             0, 1, 16'h0000, 0, 16'h1201, 1, 3, 16'h0001, 1, 0};
    vecs[11] = '{1'b0, 64'd0,            1'b1, d(1,0,0,0),        0, 1, 16'h0000, 0, 16'h1201, 0, 3, 16'h0001, 0, 0};
    vecs[12] = '{1'b0, 64'd0,            1'b0, 64'd0,             1, 1, 16'h0000, 0, 16'h1201, 0, 4, 16'h0001, 0, 0};
    vecs[13] = '{1'b1, d(2,40000,1,1),   1'b0, 64'd0,             0, 1, 16'h0000, 0, 16'h1301, 1, 5, 16'h0001, 1, 0};
    vecs[14] = '{1'b0, 64'd0,            1'b1, d(2,40001,0,1),    0, 1, 16'h0000, 0, 16'h1307, 1, 6, 16'h0001, 0, 1};
    vecs[15] = '{1'b0, 64'd0,            1'b0, 64'd0,             1, 0, 16'h0000, 0, 16'h1307, 0, 6, 16'h0001, 0, 1};
    vecs[16] = '{1'b1, d(7,100,0,0),     1'b0, 64'd0,             0, 1, 16'h0000, 0, 16'h1307, 0, 6, 16'h0001, 1, 1};
    vecs[17] = '{1'b0, 64'd0,            1'b1, d(7,200,0,0),      0, 1, 16'h0000, 1, 16'h0002, 1, 1, 16'h0002, 0, 2};
    vecs[18] = '{1'b1, d(4,64,0,0),      1'b1, d(4,64,0,0),       0, 1, 16'h0000, 0, 16'h0082, 1, 2, 16'h0002, 1, 3};
    vecs[19] = '{1'b0, 64'd0,            1'b1, d(4,64,0,0),       0, 1, 16'h0000, 0, 16'h0082, 0, 2, 16'h0002, 0, 4};

    idle();
    #2;
    check_all("reset", 16'h0, 1'b0, 0, 16'h0, 0, 0);
    #10 ap_rst_n = 1'b1;
    step();
    step();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].req_v, vecs[i].req_d, vecs[i].resp_v, vecs[i].resp_d,
            vecs[i].data_v, vecs[i].rdy, vecs[i].mask, vecs[i].clr);
      step();
      check_all($sformatf("v%0d", i), vecs[i].e_prot, vecs[i].e_vld, vecs[i].e_cnt,
                vecs[i].e_first, vecs[i].e_reqo, vecs[i].e_respo);
    end

    // Reset mid-transfer wipes tracking; orphan data right after release is ignored.
    idle();
    ap_rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'h0, 1'b0, 0, 16'h0, 0, 0);
    #1 ap_rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 16'h0, 1'b0);
    step();
    check_all("post_rst_orphan", 16'h0, 1'b0, 0, 16'h0, 0, 0);
    idle();
    step();

    // Fill the req queue, then overflow it.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, d(0,64,0,0), 1'b0, '0, 1'b0, 1'b1, 16'h0, 1'b0);
      step();
    end
    check_all("req_full", 16'h0, 1'b0, 0, 16'h0, 16, 0);
    drive(1'b1, d(0,64,0,0), 1'b0, '0, 1'b0, 1'b1, 16'h0, 1'b0);
    step();
    check_all("req_ovf", 16'h0040, 1'b1, 1, 16'h0040, 16, 0);

    // Push and pop a full queue in the same cycle: legal, occupancy unchanged.
    drive(1'b1, d(0,64,0,0), 1'b1, d(0,64,0,0), 1'b0, 1'b1, 16'h0, 1'b0);
    step();
    check_all("full_push_pop", 16'h0040, 1'b0, 1, 16'h0040, 16, 1);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
